rx_deframer: RTL
================

# rx_deframer

Serial-to-parallel deframing stage that consumes the one-bit stream produced by the receive front-end FSM. It synchronises the line, detects a start bit, samples DATA_BITS data bits LSB-first at mid-bit, checks the stop bit, and presents each good word on a valid/ready handshake to the downstream consumer. Framing errors and overruns are flagged as single-cycle pulses.

## Interface
- DATA_BITS, 8, data bits per frame (5..9)
- CLKS_PER_BIT, 16, clk cycles per serial bit; even, >= 4
- clk  input  1  rising-edge clock
- Reset  input  1  reset, asynchronous, active-low
- Enable  input  1  stage enable; deframing active only when Enable && !Disable
- Disable  input  1  stage disable; overrides Enable
- Bit_In  input  1  serial line from receive front-end; idle level 1
- Data_Out  output  DATA_BITS  received word, stable while Data_Valid=1
- Data_Valid  output  1  word held in Data_Out
- Data_Ready  input  1  consumer accepts word on a clk edge where Data_Valid && Data_Ready
- Frame_Err  output  1  one-cycle pulse: stop bit sampled 0
- Overrun  output  1  one-cycle pulse: good frame dropped because the holding register was full

## Operation
- Bit_In passes through a 2-flop synchroniser, reset value 1, giving line_s. Previous line_s is registered for falling-edge detection; reset value 1.
- Active = Enable && !Disable. When inactive, the FSM is forced to IDLE and counters clear. The holding register, Data_Valid and the handshake keep operating.
- States: IDLE, START, DATA, STOP.
- IDLE: a 1->0 edge on line_s while active moves to START and loads the bit timer with CLKS_PER_BIT/2-1.
- START: on timer expiry, sample line_s. If 0, go to DATA with timer CLKS_PER_BIT-1 and bit index 0. If 1, treat as a glitch, return to IDLE, and raise no flag.
- DATA: on each expiry, shift line_s into the shift register MSB side, so the word is LSB-first. Increment the index and reload the timer. After the bit at index DATA_BITS-1, go to STOP.
- STOP: on expiry, sample line_s, then return to IDLE.
  - Sample 1: the word is good.
  - Sample 0: pulse Frame_Err and discard the word.
- Good word, holding register empty or being consumed in the same cycle: load Data_Out and set Data_Valid.
- Good word, holding register full and not consumed: pulse Overrun, drop the new word, and leave Data_Out unchanged.
- Handshake: Data_Valid is cleared on an edge with Data_Ready=1, unless a new good word loads on that same edge; then Data_Valid stays 1 with new data.
- Data_Ready while Data_Valid=0 is ignored.
- After a framing error, IDLE needs a fresh falling edge. A line held low does not retrigger.
- Enable dropping mid-frame aborts the frame silently, with no flags.
- Reset mid-frame clears everything, including the held word.

## Timing
- Reset values: Data_Out=0, Data_Valid=0, Frame_Err=0, Overrun=0, state IDLE, synchroniser and edge register at 1.
- Let t be the cycle in which IDLE sees the falling edge on line_s. line_s lags Bit_In by 2 cycles.
- Start sample: t+CLKS_PER_BIT/2.
- Data bit k sample: t+CLKS_PER_BIT/2+(k+1)*CLKS_PER_BIT.
- Stop sample: t+CLKS_PER_BIT/2+(DATA_BITS+1)*CLKS_PER_BIT.
- Data_Valid, Frame_Err and Overrun are registered and assert on the edge after the stop sample, which is 1 cycle of output latency.
- A new start edge is accepted from the first IDLE cycle after STOP. A stop bit of 1 bit-time is sufficient for back-to-back frames.

## Structure
- Package rx_pkg holds:
  - the rx_state_t enum {IDLE, START, DATA, STOP};
  - the localparam helpers for timer width, $clog2(CLKS_PER_BIT), and index width, $clog2(DATA_BITS+1).
- One sub-module, rx_bit_timer: a down-counter with load value, load strobe, clear, and expiry flag.
- Synchroniser, FSM, shift register and holding register stay in rx_deframer.

## Test plan
- Reset, defaults: CLKS_PER_BIT=16, Enable=1, line idle -> all outputs 0, no activity for 500 cycles.
- Byte 0xA5 with stop=1 -> Data_Out=0xA5 and Data_Valid=1 exactly 1 cycle after the stop sample (t+152); Data_Ready pulse clears Data_Valid next edge.
- Glitch low for 4 cycles -> return to IDLE, no Data_Valid, no Frame_Err. Then byte 0x3C with stop=0 -> Frame_Err single pulse, Data_Valid stays 0.
- Data_Ready held 0, send 0x11 then 0x22 -> Data_Out=0x11, Overrun pulses once at the second stop. Repeat with Data_Ready=1 on the load edge of 0x22 -> Data_Out=0x22, Data_Valid stays 1, no Overrun.
- Disable=1 asserted during bit 3 of 0xFF -> frame aborted with no flags. Deassert, send 0x5A -> received correctly.
- Reset pulled low during DATA with a word held -> outputs return to reset values asynchronously. Next frame 0x81 -> received correctly.

Source files
------------

// File: rtl/rx_pkg.sv
// Shared types and width helpers for the serial receive deframer.
package rx_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  // Bit-timer width: holds CLKS_PER_BIT-1 as the largest load value.
  function automatic int timer_w(input int clks_per_bit);
    return $clog2(clks_per_bit);
  endfunction

  function automatic int idx_w(input int data_bits);
    return $clog2(data_bits + 1);
  endfunction

endpackage

// File: rtl/rx_bit_timer.sv
// Loadable down-counter that parks at zero; expired is high while the count is zero.
module rx_bit_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         Reset,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)               cnt_d = '0;
    else if (load)         cnt_d = load_val;
    else if (cnt_q != '0)  cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/rx_deframer.sv
// Start/data/stop deframer with a single-word holding register on a valid/ready output.
module rx_deframer
  import rx_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 Reset,
  input  logic                 Enable,
  input  logic                 Disable,
  input  logic                 Bit_In,
  output logic [DATA_BITS-1:0] Data_Out,
  output logic                 Data_Valid,
  input  logic                 Data_Ready,
  output logic                 Frame_Err,
  output logic                 Overrun
);

  localparam int TW = timer_w(CLKS_PER_BIT);
  localparam int IW = idx_w(DATA_BITS);
  localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_LOAD = TW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_BITS - 1);

  rx_state_t state_q, state_d;
  logic sync1_q, line_q, prev_q;
  logic [IW-1:0] idx_q, idx_d;
  logic [DATA_BITS-1:0] sh_q, sh_d, dout_q, dout_d;
  logic dvalid_q, dvalid_d, ferr_q, ferr_d, ovr_q, ovr_d;
  logic active, tmr_load, tmr_exp, good;
  logic [TW-1:0] tmr_val;

  assign active = Enable && !Disable;

  rx_bit_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .Reset    (Reset),
    .clr      (!active),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_exp)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    sh_d     = sh_q;
    tmr_load = 1'b0;
    tmr_val  = FULL_LOAD;
    good     = 1'b0;
    ferr_d   = 1'b0;
    ovr_d    = 1'b0;
    dout_d   = dout_q;
    dvalid_d = dvalid_q;

    if (!active) begin
      state_d = IDLE;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: if (prev_q && !line_q) begin
          state_d  = START;
          tmr_load = 1'b1;
          tmr_val  = HALF_LOAD;
        end
        // A high line at mid-start is a glitch; drop it without flagging.
        START: if (tmr_exp) begin
          if (!line_q) begin
            state_d  = DATA;
            idx_d    = '0;
            tmr_load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
        DATA: if (tmr_exp) begin
          sh_d     = {line_q, sh_q[DATA_BITS-1:1]};
          idx_d    = idx_q + IW'(1);
          tmr_load = 1'b1;
          if (idx_q == LAST_IDX) state_d = STOP;
        end
        STOP: if (tmr_exp) begin
          state_d = IDLE;
          if (line_q) good   = 1'b1;
          else        ferr_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end

    if (dvalid_q && Data_Ready) dvalid_d = 1'b0;
    // A consume on the same edge frees the register for the new word.
    if (good) begin
      if (!dvalid_q || Data_Ready) begin
        dout_d   = sh_q;
        dvalid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      sync1_q  <= 1'b1;
      line_q   <= 1'b1;
      prev_q   <= 1'b1;
      state_q  <= IDLE;
      idx_q    <= '0;
      sh_q     <= '0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      sync1_q  <= Bit_In;
      line_q   <= sync1_q;
      prev_q   <= line_q;
      state_q  <= state_d;
      idx_q    <= idx_d;
      sh_q     <= sh_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
    end
  end

  assign Data_Out   = dout_q;
  assign Data_Valid = dvalid_q;
  assign Frame_Err  = ferr_q;
  assign Overrun    = ovr_q;

endmodule
